// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : Writeback queue in front of the register file's single write
//               port. Results arrive over a valid/ready handshake, are held in
//               a circular buffer in arrival order, and are drained one entry
//               per cycle onto rg_wrt_*. The register file always accepts a
//               write, so the drain side never stalls.
//
// Optional feature macro:
//   WB_FWD_EN   adds a combinational lookup port (lk_addr/lk_hit/lk_data)
//               returning the youngest pending value for a register.
//
// Parameters:
//   DEPTH   queue entries (power of two, >= 2)
//   ADDR_W  register address width
//   DATA_W  register data width
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous reset, active low
//   in_valid     producer has a result
//   in_ready     queue can accept this cycle (= !full)
//   in_addr      destination register of the result
//   in_data      result value
//   rg_wrt_en    write strobe to the register file (= !empty)
//   rg_wrt_addr  head entry address, 0 when empty
//   rg_wrt_data  head entry data, 0 when empty
//   count        occupied entries
//   empty        count == 0
//   full         count == DEPTH
//   lk_addr      lookup address                 (WB_FWD_EN only)
//   lk_hit       a pending write to lk_addr      (WB_FWD_EN only)
//   lk_data      youngest pending value, else 0  (WB_FWD_EN only)
//
// Revision    : 1.0  initial release
// ============================================================================
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     rg_wrt_en,
  output logic [ADDR_W-1:0]        rg_wrt_addr,
  output logic [DATA_W-1:0]        rg_wrt_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        lk_addr,
  output logic                     lk_hit,
  output logic [DATA_W-1:0]        lk_data
`endif
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_STEP  = PTR_W'(1);

  // Entry storage. Data is never reset: only entries between the read and
  // write pointers are ever observed.
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;

  // --------------------------------------------------------------------------
  // Status, all from registered occupancy only
  // --------------------------------------------------------------------------
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == C_DEPTH);
  assign in_ready = !full;

  // A handshake to x0 completes but is not stored: writes to x0 have no
  // architectural effect, so the entry would only waste a drain slot.
  assign w_push = in_valid && in_ready && (in_addr != '0);

  // The register file takes the head on every edge it is presented.
  assign w_pop  = !empty;

  // --------------------------------------------------------------------------
  // Drain port, zeroed when idle so the register file sees clean values
  // --------------------------------------------------------------------------
  assign rg_wrt_en   = !empty;
  assign rg_wrt_addr = empty ? '0 : r_addr[r_rd_ptr];
  assign rg_wrt_data = empty ? '0 : r_data[r_rd_ptr];

  // --------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally on overflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_STEP;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write; suppressed on a reset edge so a dropped push leaves no trace.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_addr[r_wr_ptr] <= in_addr;
      r_data[r_wr_ptr] <= in_data;
    end
  end

`ifdef WB_FWD_EN
  // --------------------------------------------------------------------------
  // Lookup: walk occupied entries from oldest (read pointer) to youngest so
  // that the last match found is the most recent value for lk_addr. Only
  // queued state is searched; the current in_* beat is deliberately ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) && (lk_addr != '0) &&
          (r_addr[r_rd_ptr + PTR_W'(k)] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = r_data[r_rd_ptr + PTR_W'(k)];
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Self-checking bench for wb_write_queue. A queue-of-entries
//               reference model predicts every drain output and the sequence
//               of register file writes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int EV_W   = 1 + ADDR_W + DATA_W + CNT_W + 3;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] lk_addr = '0;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
`endif

  int total = 0;
  int bad   = 0;

  ent_t q[$];        // model: pending entries, oldest first
  ent_t mdl_log[$];  // model: writes the register file should see
  ent_t dut_log[$];  // writes the register file actually saw

  wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .count       (count),
    .empty       (empty),
    .full        (full)
`ifdef WB_FWD_EN
    ,
    .lk_addr     (lk_addr),
    .lk_hit      (lk_hit),
    .lk_data     (lk_data)
`endif
  );

  always #5 clk = ~clk;

  // Register file side: every strobe at an edge is a committed write.
  always @(posedge clk) begin
    if (rg_wrt_en === 1'b1) dut_log.push_back({rg_wrt_addr, rg_wrt_data});
  end

  // Advance the model by one edge using the inputs currently driven, then
  // let that edge happen and settle.
  task automatic tick();
    bit room;
    room = (q.size() < DEPTH);
    if (q.size() != 0) begin
      mdl_log.push_back(q[0]);
      void'(q.pop_front());
    end
    if (!reset) begin
      q.delete();
    end else if (in_valid && room && in_addr != '0) begin
      q.push_back({in_addr, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EV_W-1:0] exp_vec();
    ent_t h;
    h = '0;
    if (q.size() != 0) h = q[0];
    return {q.size() != 0, h.a, h.d, CNT_W'(q.size()),
            q.size() == 0, q.size() == DEPTH, q.size() != DEPTH};
  endfunction

  function automatic logic [EV_W-1:0] dut_vec();
    return {rg_wrt_en, rg_wrt_addr, rg_wrt_data, count, empty, full, in_ready};
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hDEAD_BEEF;
    tick();
    tick();
    total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", rg_wrt_en); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    reset = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_addr = 5'd1; in_data = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    total++;
    if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data} !== {1'b1, 5'd1, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL single_drain got=%b/%0d/%h want=1/1/ffffffff", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
    end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", empty); end
    total++;
    if (dut_log.size() == 0 || dut_log[dut_log.size()-1] !== {5'd1, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL single_commit got_writes=%0d want last=1/ffffffff", dut_log.size());
    end
  endtask

  task automatic test_x0_drop();
    int n0;
    n0 = dut_log.size();
    in_valid = 1'b1; in_addr = '0; in_data = 32'h1234_5678;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (count !== '0) begin bad++; $display("FAIL x0_count got=%0d want=0", count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL x0_en cyc=%0d got=%b want=0", i, rg_wrt_en); end
      tick();
    end
    total++; if (dut_log.size() != n0) begin bad++; $display("FAIL x0_writes got=%0d want=%0d", dut_log.size(), n0); end
  endtask

  task automatic test_back_to_back();
    int nd;
    dut_log.delete(); mdl_log.delete();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(i); in_data = $urandom;
      total++;
      if (dut_vec() !== exp_vec() || count > CNT_W'(DEPTH)) begin
        bad++; $display("FAIL b2b_state i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    total++; if (dut_log.size() != 5) begin bad++; $display("FAIL b2b_nwrites got=%0d want=5", dut_log.size()); end
    nd = 0;
    for (int i = 0; i < dut_log.size() && i < mdl_log.size(); i++) begin
      if (dut_log[i].a !== ADDR_W'(i + 1) || dut_log[i] !== mdl_log[i]) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL b2b_order diffs=%0d want=0", nd); end
  endtask

  task automatic test_reset_mid();
    dut_log.delete(); mdl_log.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(9 + i); in_data = $urandom;
      tick();
    end
    reset = 1'b0; in_addr = 5'd12; in_data = $urandom;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    total++; if (count !== '0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL rmid_en cyc=%0d got=%b want=0", i, rg_wrt_en); end
      tick();
    end
    total++;
    if (dut_log.size() != mdl_log.size() || dut_log.size() != 3) begin
      bad++; $display("FAIL rmid_writes got=%0d want=%0d", dut_log.size(), mdl_log.size());
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forward();
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hAAAA_0000;
    tick();
    in_addr = 5'd3; in_data = 32'hBBBB_1111;
    tick();
    in_valid = 1'b0;
    lk_addr = 5'd3;
    #1;
    total++;
    if ({lk_hit, lk_data} !== {1'b1, 32'hBBBB_1111}) begin
      bad++; $display("FAIL fwd_hit got=%b/%h want=1/bbbb1111", lk_hit, lk_data);
    end
    lk_addr = 5'd0;
    #1;
    total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL fwd_x0 got=%b want=0", lk_hit); end
    tick();
    tick();
  endtask
`endif

  task automatic test_random();
    int nd;
    dut_log.delete(); mdl_log.delete();
    for (int c = 0; c < 300; c++) begin
      reset    = ($urandom_range(0, 39) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = ADDR_W'($urandom_range(0, 7));
      in_data  = $urandom;
`ifdef WB_FWD_EN
      begin
        logic             e_hit;
        logic [DATA_W-1:0] e_data;
        lk_addr = ADDR_W'($urandom_range(0, 7));
        #1;
        e_hit = 1'b0; e_data = '0;
        foreach (q[i]) if (q[i].a == lk_addr && lk_addr != '0) begin e_hit = 1'b1; e_data = q[i].d; end
        total++;
        if ({lk_hit, lk_data} !== {e_hit, e_data}) begin
          bad++; $display("FAIL rnd_lookup cyc=%0d got=%b/%h want=%b/%h", c, lk_hit, lk_data, e_hit, e_data);
        end
      end
`endif
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rnd_state cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      tick();
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    tick();
    total++;
    if (dut_log.size() != mdl_log.size()) begin
      bad++; $display("FAIL rnd_nwrites got=%0d want=%0d", dut_log.size(), mdl_log.size());
    end
    nd = 0;
    for (int i = 0; i < dut_log.size() && i < mdl_log.size(); i++) begin
      if (dut_log[i] !== mdl_log[i]) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL rnd_writes diffs=%0d want=0", nd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_x0_drop();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_forward();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
